// File: rtl/fix_seq_pkg.sv
// Shared constants for FIX MsgSeqNum allocation: sequence width, BCD digit count,
// initial sequence value and scheduler FSM states.
package fix_seq_pkg;
    localparam int SEQ_W      = 24;
    localparam int SEQ_DIGITS = 6;
    localparam logic [SEQ_W-1:0] SEQ_INIT = 24'h000001;

    typedef enum logic {
        ARB = 1'b0,
        GNT = 1'b1
    } sched_state_e;
endpackage

// File: rtl/bcd_seq_incr.sv
// Combinational 6-digit packed-BCD incrementer; 999999 wraps to 000001 so that
// zero is never produced. Out-of-range digits in the carry chain normalise to 0.
module bcd_seq_incr
    import fix_seq_pkg::*;
(
    input  logic [SEQ_W-1:0] value,
    output logic [SEQ_W-1:0] result
);
    logic       carry;
    logic [3:0] digit;

    always_comb begin
        result = '0;
        carry  = 1'b1;
        digit  = '0;
        for (int i = 0; i < SEQ_DIGITS; i++) begin
            digit = value[i*4 +: 4];
            if (carry) begin
                if (digit >= 4'd9) begin
                    digit = 4'd0;
                end else begin
                    digit = digit + 4'd1;
                    carry = 1'b0;
                end
            end
            result[i*4 +: 4] = digit;
        end
        if (result == '0) result = SEQ_INIT;
    end
endmodule

// File: rtl/fix_seq_num_scheduler.sv
// Round-robin MsgSeqNum allocator for order sources sharing one FIX session;
// allocated numbers are queued in grant order for the seq-num-rewrite buffer.
module fix_seq_num_scheduler
    import fix_seq_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          cfg_seq_load,
    input  logic [SEQ_W-1:0]              cfg_seq_value,
    output logic [SEQ_W-1:0]              fix_new_seq_num,
    output logic                          fix_seq_num_vld,
    input  logic                          rd_fix_seq_num,
    output logic [SEQ_W-1:0]              next_seq_num,
    output logic [$clog2(FIFO_DEPTH):0]   q_count,
    output logic                          err_underflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = $clog2(NUM_REQ);

    sched_state_e     state, state_nxt;
    logic [RR_W-1:0]  rr_ptr;
    logic [RR_W-1:0]  win_idx;
    logic             win_found;
    logic             do_grant;
    logic             pop;
    logic             space;
    logic [SEQ_W-1:0] seq_incr;

    logic [SEQ_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    bcd_seq_incr u_incr (
        .value  (next_seq_num),
        .result (seq_incr)
    );

    assign pop   = rd_fix_seq_num && (count != '0);
    // A same-cycle pop frees a slot, so a full queue can still accept a grant.
    assign space = (count < CNT_W'(FIFO_DEPTH)) || pop;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = RR_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        case (state)
            ARB: begin
                if (!cfg_seq_load && win_found && space) begin
                    do_grant  = 1'b1;
                    state_nxt = GNT;
                end
            end
            GNT:     state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ARB;
            gnt           <= '0;
            rr_ptr        <= '0;
            next_seq_num  <= SEQ_INIT;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_underflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= do_grant ? (NUM_REQ'(1) << win_idx) : '0;

            // Load wins over the increment; it never touches queued entries.
            if (cfg_seq_load)  next_seq_num <= cfg_seq_value;
            else if (do_grant) next_seq_num <= seq_incr;

            if (do_grant) begin
                mem[wr_ptr] <= next_seq_num;
                wr_ptr      <= wr_ptr + 1'b1;
                rr_ptr      <= (win_idx == RR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({do_grant, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (rd_fix_seq_num && (count == '0)) err_underflow <= 1'b1;
        end
    end

    assign fix_new_seq_num = mem[rd_ptr];
    assign fix_seq_num_vld = (count != '0);
    assign q_count         = count;
endmodule
